// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: controller/FPU-side bundle of the FP sequencer; FPU_FLAGS_EN adds the NZCV flag path.
interface fpu_sequencer_if;
  logic       start;
  logic [1:0] op;
  logic       dbl;
  logic       busy;
  logic       done;
  logic       err;
  logic       rf_half;
  logic       opnd_we;
  logic       fpu_go;
  logic [1:0] fpu_op;
  logic       fpu_dbl;
  logic       fpu_ready;
  logic       fpu_write;
  logic       wr_half;
`ifdef FPU_FLAGS_EN
  logic [3:0] fpu_flags;
  logic [3:0] flags_out;
  logic       flags_we;
  modport master(output start, op, dbl, fpu_ready, fpu_flags,
                 input busy, done, err, rf_half, opnd_we, fpu_go, fpu_op, fpu_dbl, fpu_write, wr_half,
                 flags_out, flags_we);
  modport slave(input start, op, dbl, fpu_ready, fpu_flags,
                output busy, done, err, rf_half, opnd_we, fpu_go, fpu_op, fpu_dbl, fpu_write, wr_half,
                flags_out, flags_we);
`else
  modport master(output start, op, dbl, fpu_ready,
                 input busy, done, err, rf_half, opnd_we, fpu_go, fpu_op, fpu_dbl, fpu_write, wr_half);
  modport slave(input start, op, dbl, fpu_ready,
                output busy, done, err, rf_half, opnd_we, fpu_go, fpu_op, fpu_dbl, fpu_write, wr_half);
`endif
endinterface

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: Moore sequencer for operand read, FPU launch/wait with timeout, and FP writeback.
// Optional NZCV flag capture is enabled by defining FPU_FLAGS_EN.
module fpu_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic           clk,
  input logic           reset,
  fpu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, EXEC, WB_LO, WB_HI, DONE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]       r_op;
  logic             r_dbl, r_err, w_ready, w_abort;
  // r_cnt is 0 in the first EXEC cycle; w_cnt counts EXEC cycles including the current one
  assign w_cnt   = r_cnt + CNT_W'(1);
  assign w_ready = r_state == EXEC && r_cnt != '0 && bus.fpu_ready;
  assign w_abort = r_state == EXEC && !w_ready && TIMEOUT != 0 && w_cnt == CNT_W'(TIMEOUT);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = bus.start ? RD_LO : IDLE;
      RD_LO:   w_next = r_dbl ? RD_HI : EXEC;
      RD_HI:   w_next = EXEC;
      EXEC:    w_next = w_ready ? WB_LO : (w_abort ? DONE : EXEC);
      WB_LO:   w_next = r_dbl ? WB_HI : DONE;
      WB_HI:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_dbl   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state != EXEC ? '0 : (&r_cnt ? r_cnt : w_cnt);
      r_err   <= r_state == DONE ? 1'b0 : (w_abort ? 1'b1 : r_err);
      if (r_state == IDLE && bus.start) begin
        r_op  <= bus.op;
        r_dbl <= bus.dbl;
      end
    end
  end
  assign bus.busy      = r_state != IDLE;
  assign bus.done      = r_state == DONE;
  assign bus.err       = r_state == DONE && r_err;
  assign bus.rf_half   = r_state == RD_HI;
  assign bus.opnd_we   = r_state == RD_LO || r_state == RD_HI;
  assign bus.fpu_go    = r_state == EXEC && r_cnt == '0;
  assign bus.fpu_op    = r_op;
  assign bus.fpu_dbl   = r_dbl;
  assign bus.fpu_write = r_state == WB_LO || r_state == WB_HI;
  assign bus.wr_half   = r_state == WB_HI;
`ifdef FPU_FLAGS_EN
  logic [3:0] r_flags;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_flags <= '0;
    else if (w_ready) r_flags <= bus.fpu_flags;
  end
  assign bus.flags_out = r_flags;
  assign bus.flags_we  = r_state == DONE && !r_err;
`endif
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: directed table-driven check of the FP sequencer with TIMEOUT = 4.
module tb_fpu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fpu_sequencer_if bus();
  fpu_sequencer #(.TIMEOUT(4), .CNT_W(7)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  typedef struct {int dbl, op, k, done_c, err, rd, rfs, wr, wrs;} vec_t;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int outs();
    return int'({bus.busy, bus.done, bus.err, bus.rf_half, bus.opnd_we, bus.fpu_go,
                 bus.fpu_op, bus.fpu_dbl, bus.fpu_write, bus.wr_half});
  endfunction
  task automatic run_vec(input vec_t v, input int id, input bit poke);
    int exec1, done_c, err_v, rd, rfs, wr, wrs, go, gop, gdbl, busy_n, extra;
    exec1 = v.dbl != 0 ? 3 : 2;
    {done_c, err_v, rd, rfs, wr, wrs, go, gop, gdbl, busy_n, extra} = '0;
    bus.start = 1'b1;
    bus.op = 2'(v.op);
    bus.dbl = v.dbl[0];
    tick;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.dbl = 1'b0;
    for (int c = 1; c <= 20 && done_c == 0; c++) begin
      bus.fpu_ready = v.k != 0 && c == exec1 + v.k - 1;
      bus.start = poke && c == exec1 + 1;
      bus.dbl = poke;
      if (bus.busy) busy_n++;
      if (bus.opnd_we) begin rfs |= int'(bus.rf_half) << rd; rd++; end
      if (bus.fpu_go) begin go++; gop = int'(bus.fpu_op); gdbl = int'(bus.fpu_dbl); end
      if (bus.fpu_write) begin wrs |= int'(bus.wr_half) << wr; wr++; end
      if (bus.done) begin done_c = c; err_v = int'(bus.err); end
      tick;
    end
    bus.fpu_ready = 1'b0;
    bus.start = 1'b0;
    bus.dbl = 1'b0;
    chk($sformatf("v%0d done_cycle", id), done_c, v.done_c);
    chk($sformatf("v%0d err", id), err_v, v.err);
    chk($sformatf("v%0d busy_cycles", id), busy_n, v.done_c);
    chk($sformatf("v%0d opnd_we_count", id), rd, v.rd);
    chk($sformatf("v%0d rf_half_seq", id), rfs, v.rfs);
    chk($sformatf("v%0d fpu_write_count", id), wr, v.wr);
    chk($sformatf("v%0d wr_half_seq", id), wrs, v.wrs);
    chk($sformatf("v%0d fpu_go_count", id), go, 1);
    chk($sformatf("v%0d fpu_op_at_go", id), gop, v.op);
    chk($sformatf("v%0d fpu_dbl_at_go", id), gdbl, v.dbl);
    chk($sformatf("v%0d after_done busy/done/err", id), int'({bus.busy, bus.done, bus.err}), 0);
    if (poke) begin
      for (int c = 0; c < 10; c++) begin
        if (bus.done || bus.busy) extra++;
        tick;
      end
      chk($sformatf("v%0d ignored_start_extra", id), extra, 0);
    end
  endtask
  vec_t vecs[8] = '{
    '{0, 1, 3, 6, 0, 1, 0, 1, 0},
    '{1, 2, 2, 7, 0, 2, 2, 2, 2},
    '{0, 3, 0, 6, 1, 1, 0, 0, 0},
    '{1, 0, 0, 7, 1, 2, 2, 0, 0},
    '{0, 1, 4, 7, 0, 1, 0, 1, 0},
    '{1, 3, 4, 9, 0, 2, 2, 2, 2},
    '{0, 2, 1, 6, 1, 1, 0, 0, 0},
    '{0, 2, 2, 5, 0, 1, 0, 1, 0}
  };
  initial begin
    int n;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.dbl = 1'b0;
    bus.fpu_ready = 1'b0;
    repeat (3) tick;
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    tick;
    chk("idle_outputs", outs(), 0);
    bus.fpu_ready = 1'b1;
    tick;
    bus.fpu_ready = 1'b0;
    tick;
    chk("idle_ready_ignored", outs(), 0);
    foreach (vecs[i]) run_vec(vecs[i], i, 1'b0);
    run_vec(vecs[0], 8, 1'b1);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.dbl = 1'b1;
    bus.fpu_ready = 1'b1;
    tick;
    bus.start = 1'b0;
    n = 0;
    while (n < 12 && !bus.fpu_write) begin
      tick;
      n++;
    end
    bus.fpu_ready = 1'b0;
    chk("abort_reach_wb_lo", int'({bus.fpu_write, bus.wr_half}), 2);
    chk("abort_wb_lo_cycle", n + 1, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_async_outputs", outs(), 0);
    tick;
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done || bus.busy || bus.fpu_write) n++;
      tick;
    end
    chk("abort_no_done", n, 0);
    chk("abort_fpu_op_cleared", int'({bus.fpu_op, bus.fpu_dbl}), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_sequencer.md
Name: fpu_sequencer

Overview:
- Multicycle sequencer for the floating-point path of the multicycle ARM core.
- The main controller hands it an FP instruction with a one-cycle start pulse. The sequencer then:
  - steps the register file through the low and high halves of each operand pair (RegSrc64b),
  - launches the multicycle FPU and waits for its ready handshake, with a timeout,
  - sequences the one-half or two-half writeback (FPUWrite).
- The main controller holds its FSM while busy is high. The sequencer sits between the controller and the datapath FP operand and result registers.

Parameters:
- TIMEOUT, 64, maximum EXEC cycles to wait for fpu_ready before aborting. 0 disables the timeout.
- CNT_W, 7, width of the EXEC cycle counter. Must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request from the main controller; sampled only in IDLE
- op  in  2  FP operation code; captured on start
- dbl  in  1  1 = 64-bit (register pair), 0 = 32-bit; captured on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when the operation timed out; otherwise 0
- rf_half  out  1  register-half select to the datapath (RegSrc64b): 0 = low/even, 1 = high/odd
- opnd_we  out  1  latch the register-file read data into the operand-half register selected by rf_half
- fpu_go  out  1  one-cycle FPU launch pulse
- fpu_op  out  2  captured op, held stable while busy
- fpu_dbl  out  1  captured dbl, held stable while busy
- fpu_ready  in  1  FPU result valid; level or pulse
- fpu_write  out  1  result-half write enable to the register file (FPUWrite)
- wr_half  out  1  result half being written: 0 = low, 1 = high

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; counter = 0; captured op and dbl = 0.
  - All outputs are 0.
  - Reset mid-operation aborts immediately: no writeback and no done pulse.
- States: IDLE, RD_LO, RD_HI, EXEC, WB_LO, WB_HI, DONE. State is registered and outputs are decoded from state (Moore).
- IDLE:
  - On start = 1: capture op and dbl, go to RD_LO.
  - start is ignored in every other state, including DONE.
- RD_LO: rf_half = 0, opnd_we = 1. Next state is RD_HI if dbl, else EXEC.
- RD_HI: rf_half = 1, opnd_we = 1. Next state is EXEC.
- EXEC:
  - fpu_go = 1 only in the first EXEC cycle. The counter clears on entry and increments each EXEC cycle.
  - fpu_ready is honoured from the second EXEC cycle onward. A ready in the first cycle is ignored.
  - If fpu_ready = 1: go to WB_LO.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT: set the err latch and go to DONE, skipping writeback.
  - If ready and timeout coincide, ready wins and err stays 0.
- WB_LO: fpu_write = 1, wr_half = 0. Next state is WB_HI if dbl, else DONE.
- WB_HI: fpu_write = 1, wr_half = 1. Next state is DONE.
- DONE: done = 1 for exactly one cycle; err is driven from the latch. Next state is IDLE, and the err latch clears on exit.
- Latency from the start-sampling edge to the done cycle, with ready arriving at EXEC cycle k (k ≥ 2):
  - 32-bit: 1 + k + 2 cycles.
  - 64-bit: 2 + k + 3 cycles.
- Minimum spacing: a new start is accepted in the IDLE cycle after DONE. There are no back-to-back accepts.
- fpu_op and fpu_dbl hold their captured values from RD_LO through DONE, and are 0 after reset.

Optional Feature:
- Macro: FPU_FLAGS_EN.
- When defined:
  - Extra ports: input fpu_flags[3:0] (NZCV from the FPU), output flags_out[3:0], output flags_we.
  - fpu_flags is registered on the EXEC cycle that accepts fpu_ready.
  - flags_we = 1 in the DONE cycle only when err = 0. flags_out shows the registered value.
  - flags_out and flags_we are 0 on reset.
- When undefined: the ports are absent and no flag register is built.

Test Plan:
- Reset and idle: hold reset = 0 for 3 cycles, then release → all outputs 0, busy = 0. A fpu_ready pulse while idle is ignored.
- 32-bit op: start with op = 2'b01, dbl = 0; fpu_ready at EXEC cycle 3 → busy for 6 cycles, including:
  - one opnd_we cycle with rf_half = 0,
  - one fpu_go pulse with fpu_op = 01,
  - one fpu_write cycle with wr_half = 0,
  - done = 1 with err = 0 at cycle 6.
- 64-bit op: start with dbl = 1; fpu_ready at EXEC cycle 2 → rf_half sequence 0,1 on opnd_we; wr_half sequence 0,1 on fpu_write; done at cycle 7.
- Timeout: TIMEOUT = 4, fpu_ready held 0 → EXEC lasts 4 cycles, no fpu_write, done = 1 with err = 1; err = 0 the following cycle.
- Coincident ready and timeout, and early ready: with TIMEOUT = 4, ready in the cycle the counter reaches 4 → writeback occurs and err = 0. Ready only in the fpu_go cycle → ignored.
- Abort and ignored start: reset asserted during WB_LO → fpu_write drops asynchronously and no done follows. start pulsed during EXEC → no effect; only one done is produced.
